// File: rtl/mac_stream_sequencer_pkg.sv
// rtl/mac_stream_sequencer_pkg.sv - shared types and constants for the MAC stream sequencer
package mac_stream_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int ADDR_W_DEF = 15;

   // Cycles needed for the last skewed vector to clear the array.
   function automatic int DRAIN_CYC(input int n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/mac_stream_sequencer_skew_shift.sv
// rtl/mac_stream_sequencer_skew_shift.sv - per-row valid skew chain with synchronous clear
module mac_stream_sequencer_skew_shift #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic [DEPTH-1:0] dout
);

   logic [DEPTH-1:0] chain_q;
   logic [DEPTH-1:0] chain_d;

   always_comb begin
      chain_d    = '0;
      chain_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         chain_d[i] = chain_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign dout = chain_q;

endmodule

// File: rtl/mac_stream_sequencer.sv
// rtl/mac_stream_sequencer.sv - read-address, skew and drain sequencing for one systolic pass
module mac_stream_sequencer
   import mac_stream_sequencer_pkg::*;
#(
   parameter int ARRAY_N = 4,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LEN_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode_w,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic [LEN_W-1:0]   length,
   input  logic               hold,
   output logic               busy,
   output logic               done,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic [ARRAY_N-1:0] row_valid,
   output logic               wt_load,
   output logic               acc_en
);

   localparam int DRN_W = (DRAIN_CYC(ARRAY_N) > 1) ? $clog2(DRAIN_CYC(ARRAY_N)) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYC(ARRAY_N) - 1);

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                mode_q, mode_d;
   logic [DRN_W-1:0]    drain_q, drain_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // cnt counts reads already issued; the first read goes out on the start edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      base_d    = base_q;
      mode_d    = mode_q;
      drain_d   = drain_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_d   = ST_STREAM;
                  mode_d    = mode_w;
                  base_d    = base_addr;
                  len_d     = length;
                  cnt_d     = LEN_W'(1);
                  rd_en_d   = 1'b1;
                  rd_addr_d = base_addr;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_STREAM: begin
            if (cnt_q == len_q) begin
               state_d = ST_DRAIN;
               drain_d = DRAIN_LOAD;
            end else if (!hold) begin
               rd_en_d   = 1'b1;
               rd_addr_d = base_q + ADDR_W'(cnt_q);
               cnt_d     = cnt_q + LEN_W'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q - DRN_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         base_q    <= '0;
         mode_q    <= 1'b0;
         drain_q   <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         base_q    <= base_d;
         mode_q    <= mode_d;
         drain_q   <= drain_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   mac_stream_sequencer_skew_shift #(
      .DEPTH (ARRAY_N)
   ) u_skew (
      .clk  (clk),
      .rst  (rst),
      .din  (rd_en_q),
      .dout (row_valid)
   );

   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign wt_load = mode_q & (|row_valid);
   assign acc_en  = ~mode_q & (|row_valid);

endmodule

// File: tb/tb_mac_stream_sequencer.sv
// tb/tb_mac_stream_sequencer.sv - directed vector bench for mac_stream_sequencer
module tb_mac_stream_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        mode_w;
   logic [14:0] base_addr;
   logic [7:0]  length;
   logic        hold;
   logic        busy;
   logic        done;
   logic        rd_en;
   logic [14:0] rd_addr;
   logic [3:0]  row_valid;
   logic        wt_load;
   logic        acc_en;

   mac_stream_sequencer #(
      .ARRAY_N (4),
      .ADDR_W  (15),
      .LEN_W   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode_w    (mode_w),
      .base_addr (base_addr),
      .length    (length),
      .hold      (hold),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .row_valid (row_valid),
      .wt_load   (wt_load),
      .acc_en    (acc_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // hold_mask bit c: no read in cycle c (hold is driven during cycle c-1).
   typedef struct {
      logic        mode;
      logic [14:0] base;
      logic [7:0]  len;
      logic [15:0] hold_mask;
      int          repulse;
      int          done_cyc;
      int          rd_first;
      int          rd_last;
      int          en_first;
      int          en_last;
      int          rv3_first;
      int          rv3_last;
   } vec_t;

   vec_t        vecs[7];
   int          tests;
   int          fails;
   logic [63:0] rv0_trace;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " rd_en"}, int'(rd_en), 0);
      chk({tag, " rd_addr"}, int'(rd_addr), 0);
      chk({tag, " row_valid"}, int'(row_valid), 0);
      chk({tag, " wt_load"}, int'(wt_load), 0);
      chk({tag, " acc_en"}, int'(acc_en), 0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          n_rd, rd_f, rd_l, en_f, en_l, rv_f, rv_l;
      int          dn_cnt, dn_c, bl, other, busy1;
      logic [14:0] ea;
      string       tag;
      tag = $sformatf("v%0d", idx);
      n_rd = 0; rd_f = 0; rd_l = 0; en_f = 0; en_l = 0; rv_f = 0; rv_l = 0;
      dn_cnt = 0; dn_c = 0; bl = 0; other = 0; busy1 = 0;
      rv0_trace = '0;
      @(negedge clk);
      start     = 1'b1;
      mode_w    = v.mode;
      base_addr = v.base;
      length    = v.len;
      hold      = v.hold_mask[1];
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (rd_en) begin
            ea = v.base + 15'(n_rd);
            chk({tag, " rd_addr"}, int'(rd_addr), int'(ea));
            n_rd++;
            if (rd_f == 0) rd_f = c;
            rd_l = c;
         end
         if (v.mode ? wt_load : acc_en) begin
            if (en_f == 0) en_f = c;
            en_l = c;
         end
         if (v.mode ? acc_en : wt_load) other++;
         if (row_valid[3]) begin
            if (rv_f == 0) rv_f = c;
            rv_l = c;
         end
         if (done) begin
            dn_cnt++;
            if (dn_c == 0) dn_c = c;
         end
         if (c == 1) busy1 = int'(busy);
         if (!busy && bl == 0) bl = c;
         rv0_trace[c] = row_valid[0];
         hold  = (c + 1 < 16) ? v.hold_mask[c+1] : 1'b0;
         start = (c + 1 == v.repulse);
         @(negedge clk);
      end
      hold  = 1'b0;
      start = 1'b0;
      chk({tag, " n_reads"}, n_rd, int'(v.len));
      chk({tag, " rd_first"}, rd_f, v.rd_first);
      chk({tag, " rd_last"}, rd_l, v.rd_last);
      chk({tag, " done_cycle"}, dn_c, v.done_cyc);
      chk({tag, " done_count"}, dn_cnt, 1);
      chk({tag, " busy_cycle1"}, busy1, 1);
      chk({tag, " busy_low_cycle"}, bl, v.done_cyc + 1);
      chk({tag, " en_first"}, en_f, v.en_first);
      chk({tag, " en_last"}, en_l, v.en_last);
      chk({tag, " other_en"}, other, 0);
      chk({tag, " rv3_first"}, rv_f, v.rv3_first);
      chk({tag, " rv3_last"}, rv_l, v.rv3_last);
   endtask

   initial begin
      int dn;
      tests = 0;
      fails = 0;

      //          mode  base      len  hold     rep done rdF rdL enF enL rvF rvL
      vecs[0] = '{1'b0, 15'h0010, 8'd3, 16'h0000, 0, 12, 1, 3, 2, 7,  5, 7};
      vecs[1] = '{1'b1, 15'h0100, 8'd2, 16'h0000, 0, 11, 1, 2, 2, 6,  5, 6};
      vecs[2] = '{1'b0, 15'h0055, 8'd0, 16'h0000, 0, 1,  0, 0, 0, 0,  0, 0};
      vecs[3] = '{1'b0, 15'h0200, 8'd4, 16'h000C, 0, 15, 1, 6, 2, 10, 5, 10};
      vecs[4] = '{1'b1, 15'h7FFE, 8'd4, 16'h0000, 0, 13, 1, 4, 2, 8,  5, 8};
      vecs[5] = '{1'b0, 15'h7FFF, 8'd1, 16'h0000, 0, 10, 1, 1, 2, 5,  5, 5};
      vecs[6] = '{1'b0, 15'h0000, 8'd3, 16'h0000, 2, 12, 1, 3, 2, 7,  5, 7};

      rst       = 1'b1;
      start     = 1'b0;
      mode_w    = 1'b0;
      base_addr = '0;
      length    = '0;
      hold      = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         run_vec(i, vecs[i]);
         if (i == 3) begin
            chk("hold rv0_c2", int'(rv0_trace[2]), 1);
            chk("hold rv0_c3", int'(rv0_trace[3]), 0);
            chk("hold rv0_c4", int'(rv0_trace[4]), 0);
            chk("hold rv0_c5", int'(rv0_trace[5]), 1);
            chk("hold rv0_c7", int'(rv0_trace[7]), 1);
            chk("hold rv0_c8", int'(rv0_trace[8]), 0);
         end
      end

      // Reset asserted during cycle 3 of a pass.
      @(negedge clk);
      start     = 1'b1;
      mode_w    = 1'b0;
      base_addr = 15'h0040;
      length    = 8'd5;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("midrst rv_inflight", int'(row_valid != 4'b0000), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle_outputs("midrst");
      rst = 1'b0;
      dn = 0;
      for (int c = 0; c < 30; c++) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      chk("midrst no_done", dn, 0);
      run_vec(7, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mac_stream_sequencer.md
# mac_stream_sequencer

Sequences one streaming pass of the systolic array after the instruction decoder issues a "start streaming" command (MAC or Send-weights). Generates sequential read addresses for the input or weight buffer, produces the per-row skewed valid strobes the array needs, and waits for the pipeline to drain. It then pulses `done` so the decoder can issue Store Output. It sits between the controller's `state_signal`/`i_mode` outputs and the buffer read ports and MAC array enables.

## Interface
- `ARRAY_N`, 4, array rows/cols; skew depth and drain length derive from it
- `ADDR_W`, 15, buffer address width
- `LEN_W`, 8, stream length width (vectors per pass)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode_w`  in  1  latched at start: 1 = weight load (drive `wt_load`), 0 = MAC (drive `acc_en`)
- `base_addr`  in  ADDR_W  first read address, latched at start
- `length`  in  LEN_W  number of reads, latched at start
- `hold`  in  1  back-pressure; suppresses a read while streaming
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at end of pass
- `rd_en`  out  1  buffer read strobe
- `rd_addr`  out  ADDR_W  buffer read address
- `row_valid`  out  ARRAY_N  skewed data-valid per array row
- `wt_load`  out  1  weights being shifted in; equals OR of `row_valid` when `mode_w` is latched 1
- `acc_en`  out  1  accumulators enabled; equals OR of `row_valid` when `mode_w` is latched 0

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - `start`=1 with `length`≠0: latch `mode_w`, `base_addr` and `length`; clear read counter `cnt`; go to STREAM.
  - `start`=1 with `length`=0: go directly to DONE; no reads issued.
- STREAM:
  - Each cycle with `hold`=0: `rd_en`=1, `rd_addr`=`base+cnt` mod 2^ADDR_W (wrap 0x7FFF→0x0000), then `cnt`++.
  - Each cycle with `hold`=1: `rd_en`=0 and `cnt` holds; the skew register still shifts, so a bubble is inserted.
  - After the read with `cnt`=`length`-1, go to DRAIN. The drain counter loads 2·ARRAY_N-1.
- DRAIN:
  - `hold` is ignored.
  - The drain counter decrements each cycle. On the cycle it reaches 0, go to DONE.
  - Total DRAIN duration is 2·ARRAY_N cycles.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Skew register:
  - `row_valid[0]` is `rd_en` delayed 1 cycle, matching the buffer read latency.
  - `row_valid[i]` is `row_valid[i-1]` delayed 1 cycle.
  - It shifts in every state and clears only on reset.
- `start` outside IDLE is ignored, with no queuing.
- Counters are LEN_W wide. Address arithmetic is ADDR_W wide, truncating.

## Timing
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `wt_load`, `acc_en` = 0; `rd_addr`=0; `row_valid`=0; all counters 0.
- All outputs are registered. `wt_load` and `acc_en` are derived from registered `row_valid` and the latched mode.
- Cycle numbering with no holds, where `start` is sampled at edge 0:
  - Cycles 1..L: `rd_en`=1 and `busy`=1.
  - Cycles L+1..L+2N: DRAIN.
  - Cycle L+2N+1: `done`=1 and `busy`=1.
  - Cycle L+2N+2: `busy`=0.
- Each held cycle extends STREAM by one cycle.
- `length`=0: `done` in cycle 1, `busy`=1 for cycle 1 only.
- `rst` mid-pass takes effect at the next edge. Everything returns to reset values, no `done` is generated, and in-flight `row_valid` bits are cleared.

## Structure
- The shared package holds:
  - the FSM state encoding, `ST_IDLE`, `ST_STREAM`, `ST_DRAIN`, `ST_DONE` (2 bits);
  - the `ADDR_W` default;
  - `DRAIN_CYC(N) = 2*N`.
- One natural sub-module: `skew_shift`, an ARRAY_N-deep 1-bit shift chain with synchronous clear. The FSM, counters and address generation stay in the top module.

## Test plan
- MAC, `base`=0x010, `length`=3, N=4:
  - `rd_addr` 0x010/0x011/0x012 in cycles 1–3.
  - `row_valid[3]` high in cycles 5–7.
  - `acc_en` high in cycles 2–7, `wt_load`=0.
  - `done` in cycle 12.
- Weight mode, `base`=0x100, `length`=2: `wt_load` high in cycles 2–6, `acc_en` never high, `done` in cycle 11.
- `length`=0: `done` in cycle 1, `rd_en` never asserted, `busy` low from cycle 2.
- `length`=4 with `hold` high in cycles 2–3:
  - `rd_addr` sequence base+0,+1,+2,+3 in cycles 1,4,5,6.
  - `row_valid[0]` low in cycles 3–4.
  - `done` in cycle 15.
- Wrap, `base`=0x7FFE, `length`=4: addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Busy and reset cases:
  - `start` re-pulsed in cycle 2 of a pass: ignored, one `done` only.
  - `rst` in cycle 3: all outputs 0 next cycle, no `done`; a new `start` afterwards completes normally.
